// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM encoding
// and the port identifiers used by the round-robin picker.
package dmem_arbiter_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic CORE = 1'b0;
   localparam logic DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last. The pointer only moves when a grant is taken.
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       valid,
   output logic       pick
);

   logic last;

   // Reset to DBG so that the core wins the very first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last <= DBG;
      else if (advance && valid)
         last <= pick;
   end

   always_comb begin
      valid = |req;
      pick  = CORE;
      if (req[CORE] && req[DBG])
         pick = ~last;
      else if (req[DBG])
         pick = DBG;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core port and a debug/loader port onto one single-port data RAM.
// Each access takes three cycles: grant (IDLE), RAM strobe (ACCESS), done (RESP).
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_done,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_ld,
   output logic              m_str,
   input  logic [DATA_W-1:0] m_rdata
);

   state_t            state, state_next;
   logic              win_id;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              arb_valid;
   logic              arb_pick;
   logic              grant;

   // Grants are suppressed while reset is held so nothing is taken before release.
   assign grant = (state == IDLE) && arb_valid && !reset;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({d_req, c_req}),
      .advance (grant),
      .valid   (arb_valid),
      .pick    (arb_pick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      c_gnt      = 1'b0;
      d_gnt      = 1'b0;
      c_done     = 1'b0;
      d_done     = 1'b0;
      m_ld       = 1'b0;
      m_str      = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_next = ACCESS;
               c_gnt      = (arb_pick == CORE);
               d_gnt      = (arb_pick == DBG);
            end
         end
         ACCESS: begin
            m_str      = lat_we;
            m_ld       = !lat_we;
            state_next = RESP;
         end
         RESP: begin
            c_done     = (win_id == CORE);
            d_done     = (win_id == DBG);
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The winner's request is frozen here so later req changes cannot disturb it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_id    <= CORE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else if (grant) begin
         win_id    <= arb_pick;
         lat_we    <= (arb_pick == CORE) ? c_we    : d_we;
         lat_addr  <= (arb_pick == CORE) ? c_addr  : d_addr;
         lat_wdata <= (arb_pick == CORE) ? c_wdata : d_wdata;
      end
   end

   assign m_addr  = lat_addr;
   assign m_wdata = lat_wdata;

   // Per-port read registers: only the winning port's word changes, and only on loads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         c_rdata <= '0;
         d_rdata <= '0;
      end else if (state == ACCESS && !lat_we) begin
         if (win_id == CORE)
            c_rdata <= m_rdata;
         else
            d_rdata <= m_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM; inputs change #1 after
// the rising edge and outputs are compared on the falling edge.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [11:0] c_addr, d_addr, m_addr;
   logic [31:0] c_wdata, d_wdata, m_wdata, m_rdata;
   logic        c_gnt, c_done, d_gnt, d_done, m_ld, m_str;
   logic [31:0] c_rdata, d_rdata;
   logic [31:0] mem [0:4095];
   int          checks = 0;
   int          errors = 0;

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .c_req   (c_req),
      .c_we    (c_we),
      .c_addr  (c_addr),
      .c_wdata (c_wdata),
      .c_gnt   (c_gnt),
      .c_done  (c_done),
      .c_rdata (c_rdata),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_gnt   (d_gnt),
      .d_done  (d_done),
      .d_rdata (d_rdata),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_ld    (m_ld),
      .m_str   (m_str),
      .m_rdata (m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with combinational read.
   assign m_rdata = mem[m_addr];
   always @(posedge clk) begin
      if (m_str)
         mem[m_addr] <= m_wdata;
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Mutual-exclusion invariants hold on every cycle of every test.
   always @(negedge clk) begin
      checks++;
      assert (!(m_ld && m_str) && !(c_gnt && d_gnt)) else begin
         errors++;
         $error("[TB] FAIL exclusivity: m_ld=%b m_str=%b c_gnt=%b d_gnt=%b",
                m_ld, m_str, c_gnt, d_gnt);
      end
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[12'h020] = 32'hCAFEF00D;
      reset   = 1'b1;
      c_req   = 1'b1;
      c_we    = 1'b0;
      c_addr  = 12'h0;
      c_wdata = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 12'h0;
      d_wdata = 32'h0;

      // Reset state, with a core request pending that must not be granted
      @(negedge clk);
      check_output("rst_c_gnt", c_gnt, 0);
      check_output("rst_d_gnt", d_gnt, 0);
      check_output("rst_m_str", m_str, 0);
      check_output("rst_m_ld", m_ld, 0);
      check_output("rst_m_addr", m_addr, 0);
      check_output("rst_m_wdata", m_wdata, 0);
      check_output("rst_c_rdata", c_rdata, 0);
      check_output("rst_d_rdata", d_rdata, 0);
      next_cycle();
      reset = 1'b0;
      c_req = 1'b0;

      // Core store 0x010 <= DEADBEEF
      next_cycle();
      c_req = 1'b1; c_we = 1'b1; c_addr = 12'h010; c_wdata = 32'hDEADBEEF;
      @(negedge clk);
      check_output("st_c_gnt", c_gnt, 1);
      check_output("st_d_gnt", d_gnt, 0);
      check_output("st_n_strobe", m_str, 0);
      next_cycle();
      c_req = 1'b0;
      @(negedge clk);
      check_output("st_m_str", m_str, 1);
      check_output("st_m_ld", m_ld, 0);
      check_output("st_m_addr", m_addr, 12'h010);
      check_output("st_m_wdata", m_wdata, 32'hDEADBEEF);
      check_output("st_early_done", c_done, 0);
      next_cycle();
      @(negedge clk);
      check_output("st_c_done", c_done, 1);
      check_output("st_d_done", d_done, 0);
      check_output("st_resp_m_str", m_str, 0);
      check_output("st_ram", mem[12'h010], 32'hDEADBEEF);
      next_cycle();

      // Core load 0x010
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'h010; c_wdata = 32'h0;
      @(negedge clk);
      check_output("ld_c_gnt", c_gnt, 1);
      next_cycle();
      c_req = 1'b0;
      @(negedge clk);
      check_output("ld_m_ld", m_ld, 1);
      check_output("ld_m_str", m_str, 0);
      check_output("ld_m_addr", m_addr, 12'h010);
      next_cycle();
      @(negedge clk);
      check_output("ld_c_done", c_done, 1);
      check_output("ld_c_rdata", c_rdata, 32'hDEADBEEF);
      check_output("ld_d_rdata", d_rdata, 0);
      next_cycle();

      // Reset, then both ports load continuously from the first released cycle
      reset = 1'b1;
      next_cycle();
      reset  = 1'b0;
      c_req  = 1'b1; c_we = 1'b0; c_addr = 12'h010;
      d_req  = 1'b1; d_we = 1'b0; d_addr = 12'h020;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check_output($sformatf("rr_c_gnt_%0d", i), c_gnt, (i % 6) == 0);
         check_output($sformatf("rr_d_gnt_%0d", i), d_gnt, (i % 6) == 3);
         check_output($sformatf("rr_c_done_%0d", i), c_done, (i % 6) == 2);
         check_output($sformatf("rr_d_done_%0d", i), d_done, (i % 6) == 5);
         if (i == 2 || i == 8) check_output("rr_c_rdata", c_rdata, 32'hDEADBEEF);
         if (i == 5) check_output("rr_d_rdata", d_rdata, 32'hCAFEF00D);
         next_cycle();
      end
      c_req = 1'b0;
      d_req = 1'b0;
      next_cycle();

      // Debug store to 0x020 aborted by reset during ACCESS
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h020; d_wdata = 32'h11111111;
      @(negedge clk);
      check_output("ab_d_gnt", d_gnt, 1);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check_output("ab_m_str_before", m_str, 1);
      #1;
      reset = 1'b1;
      #1;
      check_output("ab_m_str_after", m_str, 0);
      check_output("ab_m_addr", m_addr, 0);
      check_output("ab_d_rdata", d_rdata, 0);
      @(negedge clk);
      check_output("ab_d_done", d_done, 0);
      check_output("ab_ram", mem[12'h020], 32'hCAFEF00D);
      next_cycle();
      reset = 1'b0;
      next_cycle();
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h020;
      @(negedge clk);
      check_output("ab_rd_d_gnt", d_gnt, 1);
      next_cycle();
      d_req = 1'b0;
      next_cycle();
      @(negedge clk);
      check_output("ab_rd_d_done", d_done, 1);
      check_output("ab_rd_d_rdata", d_rdata, 32'hCAFEF00D);
      next_cycle();

      // Debug store to the top address, then core load of it
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'hFFF; d_wdata = 32'h12345678;
      @(negedge clk);
      check_output("top_d_gnt", d_gnt, 1);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check_output("top_m_addr", m_addr, 12'hFFF);
      check_output("top_m_str", m_str, 1);
      next_cycle();
      @(negedge clk);
      check_output("top_d_done", d_done, 1);
      check_output("top_st_d_rdata", d_rdata, 32'hCAFEF00D);
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 12'hFFF;
      @(negedge clk);
      check_output("top_c_gnt", c_gnt, 1);
      next_cycle();
      c_req = 1'b0;
      next_cycle();
      @(negedge clk);
      check_output("top_c_done", c_done, 1);
      check_output("top_d_done_low", d_done, 0);
      check_output("top_c_rdata", c_rdata, 32'h12345678);
      check_output("top_d_rdata", d_rdata, 32'hCAFEF00D);
      next_cycle();
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
